// File: rtl/codificador_pkg.sv
// codificador_pkg: encoding modes and shared widths for the stream encoder
package codificador_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_IDENT  = 2'd0;
  localparam mode_t MODE_GRAY   = 2'd1;
  localparam mode_t MODE_EXCESS = 2'd2;
  localparam mode_t MODE_NEG    = 2'd3;
  localparam int COUNT_W = 16;
endpackage

// File: rtl/codificador_core.sv
// codificador_core: combinational word encoder (identity, Gray, excess-OFFSET, negate)
module codificador_core
  import codificador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int OFFSET = 3
) (
  input  logic [WIDTH-1:0] x,
  input  mode_t            mode,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  localparam logic [WIDTH:0]   OFF_EXT  = (WIDTH+1)'(OFFSET);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] neg;
  always_comb begin
    sum  = {1'b0, x} + OFF_EXT;
    gray = x ^ (x >> 1);
    neg  = ~x + 1'b1;
    y    = (mode == MODE_IDENT)  ? x :
           (mode == MODE_GRAY)   ? gray :
           (mode == MODE_EXCESS) ? sum[WIDTH-1:0] : neg;
    ovf  = (mode == MODE_EXCESS) ? sum[WIDTH] :
           (mode == MODE_NEG)    ? (x == MOST_NEG) : 1'b0;
  end
endmodule

// File: rtl/codificador_stream.sv
// codificador_stream: handshaked encoder feeding a DEPTH-entry output FIFO
module codificador_stream
  import codificador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int OFFSET = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   level,
  output logic [COUNT_W-1:0]       count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0]   data_q [DEPTH];
  logic               ovf_q  [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   enc_y;
  logic               enc_ovf;
  logic               push, pop;
  codificador_core #(.WIDTH(WIDTH), .OFFSET(OFFSET)) u_core (
    .x    (in_data),
    .mode (mode),
    .y    (enc_y),
    .ovf  (enc_ovf)
  );
  always_comb begin
    in_ready  = (level_q != LW'(DEPTH));
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    count_d   = push ? count_q + 1'b1 : count_q;
    out_data  = out_valid ? data_q[rd_ptr_q] : '0;
    out_ovf   = out_valid && ovf_q[rd_ptr_q];
    level     = level_q;
    count     = count_q;
  end
  // Storage needs no reset: the head is masked whenever level is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= enc_y;
      ovf_q[wr_ptr_q]  <= enc_ovf;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_codificador_stream.sv
// tb_codificador_stream: directed checks of encoding, FIFO flow control and async reset
module tb_codificador_stream;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_data;
  logic [1:0]  mode;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic        out_ovf;
  logic [2:0]  level;
  logic [15:0] count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  codificador_stream #(.WIDTH(4), .DEPTH(4), .OFFSET(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .level     (level),
    .count     (count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic head(input string tag, input logic [3:0] d, input logic o);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
  endtask
  logic [3:0] gray_exp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] ss_mode [6] = '{2, 3, 2, 3, 2, 3};
  logic [3:0] ss_in   [6] = '{13, 8, 1, 5, 14, 0};
  logic [3:0] ss_d    [8] = '{6, 5, 0, 8, 4, 11, 1, 0};
  logic       ss_o    [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    cyc();
    reset = 1'b1; out_ready = 1'b1; mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      cyc();
      head("gray", gray_exp[i], 1'b0);
      chk("gray_level", 32'(level), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("gray_count", 32'(count), 16);
    chk("gray_drained", 32'(out_valid), 0);
    chk("empty_data", 32'(out_data), 0);
    mode = 2'd2; in_valid = 1'b1; in_data = 4'd9;
    cyc();
    head("exc9", 4'd12, 1'b0);
    in_data = 4'd13;
    cyc();
    head("exc13", 4'd0, 1'b1);
    mode = 2'd3; in_data = 4'd1;
    cyc();
    head("neg1", 4'd15, 1'b0);
    in_data = 4'd8;
    cyc();
    head("neg8", 4'd8, 1'b1);
    in_data = 4'd0;
    cyc();
    head("neg0", 4'd0, 1'b0);
    in_valid = 1'b0;
    cyc();
    chk("count21", 32'(count), 21);
    out_ready = 1'b0; mode = 2'd0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 4'(i);
      cyc();
      chk("bp_level", 32'(level), 32'(i));
    end
    chk("bp_in_ready", 32'(in_ready), 0);
    head("bp_head", 4'd1, 1'b0);
    in_data = 4'd5;
    cyc();
    chk("bp_hold_level", 32'(level), 4);
    chk("bp_hold_count", 32'(count), 25);
    out_ready = 1'b1;
    cyc();
    head("bp_out2", 4'd2, 1'b0);
    chk("bp_level3", 32'(level), 3);
    cyc();
    in_valid = 1'b0;
    head("bp_out3", 4'd3, 1'b0);
    chk("bp_count26", 32'(count), 26);
    cyc();
    head("bp_out4", 4'd4, 1'b0);
    cyc();
    head("bp_out5", 4'd5, 1'b0);
    cyc();
    chk("bp_empty", 32'(out_valid), 0);
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0; in_data = 4'd6;
    cyc();
    mode = 2'd1;
    cyc();
    chk("ss_level_init", 32'(level), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mode = ss_mode[i][1:0]; in_data = ss_in[i];
      head("ss_head", ss_d[i], ss_o[i]);
      cyc();
      chk("ss_level", 32'(level), 2);
    end
    in_valid = 1'b0;
    head("ss_head6", ss_d[6], ss_o[6]);
    cyc();
    head("ss_head7", ss_d[7], ss_o[7]);
    cyc();
    chk("ss_empty", 32'(out_valid), 0);
    chk("ss_count", 32'(count), 34);
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'd0;
    for (int i = 7; i <= 9; i++) begin
      in_data = 4'(i);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_count", 32'(count), 37);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_data", 32'(out_data), 0);
    cyc();
    reset = 1'b1; in_valid = 1'b1; mode = 2'd1; in_data = 4'd10;
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    head("post_rst", 4'd15, 1'b0);
    chk("post_rst_count", 32'(count), 1);
    cyc();
    chk("post_rst_empty", 32'(out_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/codificador_stream.md
Name: codificador_stream

Overview:
- Parametrised, clocked successor of the 4-bit combinational encoder.
- Accepts WIDTH-bit words over a valid/ready handshake and encodes each word in one of four modes.
- Buffers encoded words, each with an overflow flag, in a DEPTH-entry FIFO and drains them over a valid/ready output handshake.
- Sits between the input capture logic and the transmit/display stage of the coding system.

Parameters:
- WIDTH, 4, data word width in bits (>=2).
- DEPTH, 4, output FIFO entries (power of two, >=2).
- OFFSET, 3, constant added in excess mode (0 <= OFFSET < 2^WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  in_data/mode valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  raw word.
- mode  in  2  encoding mode, sampled with each accepted word.
- out_valid  out  1  out_data/out_ovf valid.
- out_ready  in  1  downstream consumes the word.
- out_data  out  WIDTH  encoded word at FIFO head.
- out_ovf  out  1  overflow flag of the head word.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- count  out  16  total words accepted since reset.

Behaviour:
- Reset (reset=0, asynchronous): FIFO flushed, read/write pointers = 0, level=0, out_valid=0, in_ready=1, out_data=0, out_ovf=0, count=0.
- Reset mid-operation discards all queued words immediately, without waiting for a clock edge.
- in_ready = (level != DEPTH), combinational from registered level. No dependence on out_ready, so there is no full-FIFO bypass.
- Accept: in_valid && in_ready at a rising edge.
  - The word is encoded combinationally and written to the tail.
  - Latency is one cycle: word accepted at edge N appears at the head with out_valid=1 after edge N, if the FIFO was empty.
- Pop: out_valid && out_ready at a rising edge advances the head.
- out_valid = (level != 0). out_data/out_ovf are the head entry; they are 0 when the FIFO is empty.
- Simultaneous accept and pop (0 < level < DEPTH): both occur and level is unchanged.
- At level=0 only an accept can occur. At level=DEPTH only a pop can occur.
- Pointers wrap modulo DEPTH.
- Mode is captured per word. Changing mode never alters words already queued.
- Encoding of x = in_data, all arithmetic modulo 2^WIDTH:
  - mode 0 identity: y=x, ovf=0.
  - mode 1 Gray: y = x ^ (x>>1), ovf=0.
  - mode 2 excess-OFFSET: y = x+OFFSET, ovf = carry out of bit WIDTH-1.
  - mode 3 two's-complement negate: y = ~x+1, ovf = (x == 1 followed by WIDTH-1 zeros), i.e. the most negative value.
- count increments on each accept and wraps from 65535 to 0.
- in_data/mode are don't-care when in_valid=0.

Decomposition:
- Shared package codificador_pkg holds:
  - mode constants MODE_IDENT=0, MODE_GRAY=1, MODE_EXCESS=2, MODE_NEG=3;
  - the 2-bit mode typedef;
  - COUNT_W=16.
- One natural sub-module, codificador_core: purely combinational, parametrised by WIDTH/OFFSET, mapping (x, mode) to (y, ovf).
- The FIFO, pointers, level and count logic live in codificador_stream.

Test Plan (WIDTH=4, DEPTH=4, OFFSET=3):
- Reset to 1, out_ready=1, mode=1, sweep in_data 0..15 one per cycle -> Gray outputs 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, each one cycle after accept, out_ovf=0, count=16.
- mode=2, words 9 and 13 -> out_data 12 with ovf=0, then 0 with ovf=1.
- mode=3, words 1, 8, 0 -> out_data 15 ovf=0, 8 ovf=1, 0 ovf=0.
- out_ready=0, mode=0, offer words 1..5 back-to-back:
  - 1..4 accepted, in_ready=0 after the 4th, level=4, word 5 held off;
  - then set out_ready=1 -> outputs 1,2,3,4 then 5, in order, with no loss or duplication.
- Level=2 steady, simultaneous accept and pop for 6 cycles with alternating modes -> level stays 2, each output matches the mode captured at its own accept.
- With level=3, drop reset to 0 between clock edges -> out_valid=0, level=0, count=0, in_ready=1 before the next edge. After reset is released, the first new word emerges with the normal one-cycle latency.
